mem_port_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency memory between the fetch path (I port, read-only)
//  and the load/store path (D port, read/write) of the multi-cycle CPU.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter_arb_rr2.sv | 20 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and owner ids for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory signals shared by the arbiter and its users
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  logic          busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// rtl/mem_port_arbiter_arb_rr2.sv - combinational two-way round-robin picker (bit0 = I, bit1 = D)
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_win,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_win == OWN_D) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency single-port memory between fetch and load/store paths
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be within 1..15");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_win_q, last_win_d;
  logic             we_q, we_d;
  logic             m_en_q, m_en_d;
  logic             m_we_q, m_we_d;
  logic [AW-1:0]    m_addr_q, m_addr_d;
  logic [DW-1:0]    m_wdata_q, m_wdata_d;
  logic             i_ack_q, i_ack_d;
  logic             d_ack_q, d_ack_d;
  logic [DW-1:0]    i_rdata_q, i_rdata_d;
  logic [DW-1:0]    d_rdata_q, d_rdata_d;
  logic             busy_q, busy_d;
  logic [1:0]       grant;

  arb_rr2 u_arb (
    .req      ({bus.d_req, bus.i_req}),
    .last_win (last_win_q),
    .grant    (grant)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_win_d = last_win_q;
    we_d       = we_q;
    m_en_d     = 1'b0;
    m_we_d     = 1'b0;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant[1]) begin
          owner_d   = OWN_D;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          we_d      = bus.d_we;
        end else if (grant[0]) begin
          owner_d  = OWN_I;
          m_addr_d = bus.i_addr;
          we_d     = 1'b0;
        end
        if (|grant) begin
          last_win_d = grant[1];
          m_en_d     = 1'b1;
          m_we_d     = grant[1] & bus.d_we;
          cnt_d      = CNT_W'(MEM_LAT - 1);
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        // Read data arrives MEM_LAT cycles after m_en, which is this cycle; writes keep old rdata.
        if (!we_q) begin
          if (owner_q == OWN_D) d_rdata_d = bus.m_rdata;
          else                  i_rdata_d = bus.m_rdata;
        end
        if (owner_q == OWN_D) d_ack_d = 1'b1;
        else                  i_ack_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_I;
      last_win_q <= OWN_I;
      we_q       <= 1'b0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_win_q <= last_win_d;
      we_q       <= we_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.m_en    = m_en_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a transaction-level timeline model
module tb_mem_port_arbiter;

  localparam int L   = 2;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int base_cyc;
  bit mon_on = 1'b0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) b ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1.slave)
  );

  typedef struct {
    int          gap;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        port;
    int          at;
    logic [31:0] rdata;
  } exp_ack_t;

  typedef struct {
    int          at;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_mem_t;

  txn_t     plan_i[$];
  txn_t     plan_d[$];
  exp_ack_t exp_acks[$];
  exp_mem_t exp_mems[$];

  // Memory models: data = byte address * 4, present only in the exact cycle MEM_LAT after m_en.
  bit          h2_v[3];
  logic [31:0] h2_a[3];
  always @(posedge clk) begin
    #1;
    for (int k = 2; k > 0; k--) begin
      h2_v[k] = h2_v[k-1];
      h2_a[k] = h2_a[k-1];
    end
    h2_v[0] = b.m_en;
    h2_a[0] = b.m_addr;
    b.m_rdata = h2_v[L] ? (h2_a[L] << 2) : $urandom;
  end

  bit          h1_v[2];
  logic [31:0] h1_a[2];
  always @(posedge clk) begin
    #1;
    h1_v[1] = h1_v[0];
    h1_a[1] = h1_a[0];
    h1_v[0] = b1.m_en;
    h1_a[0] = b1.m_addr;
    b1.m_rdata = h1_v[1] ? (h1_a[1] << 2) : $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_i_ack"},   32'(b.i_ack),   0);
    chk({tag, "_d_ack"},   32'(b.d_ack),   0);
    chk({tag, "_m_en"},    32'(b.m_en),    0);
    chk({tag, "_m_we"},    32'(b.m_we),    0);
    chk({tag, "_m_addr"},  b.m_addr,       0);
    chk({tag, "_m_wdata"}, b.m_wdata,      0);
    chk({tag, "_i_rdata"}, b.i_rdata,      0);
    chk({tag, "_d_rdata"}, b.d_rdata,      0);
    chk({tag, "_busy"},    32'(b.busy),    0);
  endtask

  // Timeline model: a grant happens at the first cycle the arbiter is free and someone waits;
  // the ack cycle is grant+L+2 and the arbiter can grant again in that same cycle.
  task automatic build_model();
    int          t_free, g, first, ack;
    int          arr[2];
    int          idx[2];
    int          n[2];
    logic        last;
    logic [31:0] rd[2];
    logic [31:0] mw;
    bit          ri, rq, win;
    txn_t        t;
    exp_ack_t    ea;
    exp_mem_t    em;
    n[0] = plan_i.size();
    n[1] = plan_d.size();
    idx[0] = 0; idx[1] = 0;
    rd[0] = 0;  rd[1] = 0;
    mw = 0;
    last = 1'b0;
    t_free = base_cyc;
    arr[0] = (n[0] > 0) ? base_cyc + plan_i[0].gap : BIG;
    arr[1] = (n[1] > 0) ? base_cyc + plan_d[0].gap : BIG;
    while (idx[0] < n[0] || idx[1] < n[1]) begin
      first = (arr[0] < arr[1]) ? arr[0] : arr[1];
      g  = (first > t_free) ? first : t_free;
      ri = (arr[0] <= g);
      rq = (arr[1] <= g);
      win = (ri && rq) ? ~last : rq;
      t = win ? plan_d[idx[1]] : plan_i[idx[0]];
      if (win) mw = t.wdata;
      em.at = g + 1; em.we = win & t.we; em.addr = t.addr; em.wdata = mw;
      exp_mems.push_back(em);
      if (!(win && t.we)) rd[win] = t.addr << 2;
      ack = g + L + 2;
      ea.port = win; ea.at = ack; ea.rdata = rd[win];
      exp_acks.push_back(ea);
      last = win;
      t_free = ack;
      idx[win]++;
      if (idx[win] < n[win]) arr[win] = ack + (win ? plan_d[idx[win]].gap : plan_i[idx[win]].gap);
      else                   arr[win] = BIG;
    end
  endtask

  task automatic drive_port(input bit p);
    int   n;
    int   waited;
    txn_t t;
    n = p ? plan_d.size() : plan_i.size();
    for (int k = 0; k < n; k++) begin
      t = p ? plan_d[k] : plan_i[k];
      if (k == 0) begin
        while (cyc < base_cyc + t.gap) @(negedge clk);
      end else if (t.gap > 0) begin
        if (p) b.d_req = 1'b0; else b.i_req = 1'b0;
        repeat (t.gap) @(negedge clk);
      end
      if (p) begin
        b.d_we = t.we; b.d_addr = t.addr; b.d_wdata = t.wdata; b.d_req = 1'b1;
      end else begin
        b.i_addr = t.addr; b.i_req = 1'b1;
      end
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!(p ? b.d_ack : b.i_ack) && waited < 100);
      if (!(p ? b.d_ack : b.i_ack)) begin
        n_cmp++;
        n_err++;
        $display("FAIL ack_timeout port=%0d txn=%0d: got no ack want ack within 100 cycles", p, k);
        if (p) b.d_req = 1'b0; else b.i_req = 1'b0;
        return;
      end
    end
    if (p) b.d_req = 1'b0; else b.i_req = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_ack_t ea;
    exp_mem_t em;
    chk("m_we_outside_m_en", 32'(b.m_we & ~b.m_en), 0);
    if (b.i_ack || b.d_ack) begin
      chk("ack_exclusive", 32'(b.i_ack & b.d_ack), 0);
      if (exp_acks.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b at cycle %0d want none", b.i_ack, b.d_ack, cyc);
      end else begin
        ea = exp_acks.pop_front();
        chk("ack_port",  32'(b.d_ack), 32'(ea.port));
        chk("ack_cycle", cyc, ea.at);
        chk("ack_rdata", b.d_ack ? b.d_rdata : b.i_rdata, ea.rdata);
        chk("ack_busy",  32'(b.busy), 0);
      end
    end
    if (mon_on && b.m_en) begin
      if (exp_mems.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_m_en: got m_en=1 at cycle %0d want none", cyc);
      end else begin
        em = exp_mems.pop_front();
        chk("m_en_cycle", cyc, em.at);
        chk("m_we",       32'(b.m_we), 32'(em.we));
        chk("m_addr",     b.m_addr, em.addr);
        chk("m_wdata",    b.m_wdata, em.wdata);
        chk("m_en_busy",  32'(b.busy), 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want summary before timeout");
    $fatal(1);
  end

  initial begin
    int   c0;
    int   d_seen;
    int   waited;
    txn_t t;

    rst = 1'b1; rst1 = 1'b1;
    b.i_req = 0; b.i_addr = 0; b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_wdata = 0;
    b1.i_req = 0; b1.i_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a D read: no ack, everything back to zero.
    b.d_req = 1'b1; b.d_we = 1'b0; b.d_addr = 32'h200; b.d_wdata = 32'h0;
    c0 = cyc;
    @(negedge clk);
    chk("abort_m_en", 32'(b.m_en), 1);
    @(negedge clk);
    rst = 1'b1;
    b.d_req = 1'b0;
    @(negedge clk);
    chk_outs_zero("abort");
    rst = 1'b0;
    d_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b.d_ack) d_seen++;
    end
    chk("abort_no_d_ack", d_seen, 0);

    // Directed heads (lone fetch / contention / write) followed by random traffic.
    t.gap = 0; t.we = 0; t.addr = 32'h40; t.wdata = 0;           plan_i.push_back(t);
    t.gap = 0; t.we = 0; t.addr = 32'h80; t.wdata = 32'h1234;    plan_d.push_back(t);
    t.gap = 0; t.we = 1; t.addr = 32'h80; t.wdata = 32'hDEADBEEF; plan_d.push_back(t);
    for (int k = 0; k < 30; k++) begin
      t.gap = $urandom_range(0, 3); t.we = 0;
      t.addr = $urandom & 32'h3FFF_FFFC; t.wdata = $urandom;
      plan_i.push_back(t);
      t.gap = $urandom_range(0, 3); t.we = $urandom_range(0, 1);
      t.addr = $urandom & 32'h3FFF_FFFC; t.wdata = $urandom;
      plan_d.push_back(t);
    end
    base_cyc = cyc + 2;
    build_model();
    mon_on = 1'b1;
    fork
      drive_port(1'b0);
      drive_port(1'b1);
    join
    repeat (8) @(negedge clk);
    chk("acks_outstanding", exp_acks.size(), 0);
    chk("m_en_outstanding", exp_mems.size(), 0);
    mon_on = 1'b0;

    // MEM_LAT=1 build: back-to-back fetches.
    @(negedge clk);
    c0 = cyc;
    b1.i_addr = 32'h0; b1.i_req = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!b1.i_ack && waited < 20);
    chk("lat1_ack1_cycle", cyc, c0 + 3);
    chk("lat1_rdata1", b1.i_rdata, 32'h0);
    b1.i_addr = 32'h4;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!b1.i_ack && waited < 20);
    chk("lat1_ack2_cycle", cyc, c0 + 6);
    chk("lat1_rdata2", b1.i_rdata, 32'h10);
    b1.i_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
